// File: rtl/mem_scan_reader.sv
// mem_scan_reader: streams a contiguous, wrapping range of a register array out over valid/ready
// ports: clk, rst (async, active-high); wr_en/wr_addr/wr_data write the array in any state;
//        start/base_addr/count request a scan (count 0 = DEPTH words);
//        dd/dd_addr/dd_valid/dd_ready carry the scanned words; busy covers the scan, done pulses at its end
module mem_scan_reader #(
    parameter int DW = 8,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    output logic [DW-1:0] dd,
    output logic [AW-1:0] dd_addr,
    output logic          dd_valid,
    input  logic          dd_ready,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
    state_t state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0] rem;
    logic [AW-1:0] nxt;
    assign nxt = dd_addr + AW'(1);
    // non-blocking write: reads on the same edge see the old content
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            dd       <= '0;
            dd_addr  <= '0;
            dd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        rem      <= (count == '0) ? (AW+1)'(DEPTH) : {1'b0, count};
                        dd       <= mem[base_addr];
                        dd_addr  <= base_addr;
                        dd_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                SCAN:
                    if (dd_valid && dd_ready) begin
                        if (rem == (AW+1)'(1)) begin
                            dd_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            rem     <= rem - (AW+1)'(1);
                            dd      <= mem[nxt];
                            dd_addr <= nxt;
                        end
                    end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_scan_reader.md
MEM_SCAN_READER -- requirements
Module: mem_scan_reader

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of array entries.
REQ-003 SHALL have parameter AW, default 4, meaning address width, where DEPTH = 2**AW.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: array write strobe.
REQ-007 SHALL have port wr_addr, input, AW bits: array write address.
REQ-008 SHALL have port wr_data, input, DW bits: array write data.
REQ-009 SHALL have port start, input, 1 bit: single-cycle scan request.
REQ-010 SHALL have port base_addr, input, AW bits: first address of the scan.
REQ-011 SHALL have port count, input, AW bits: number of words to scan; 0 means DEPTH words.
REQ-012 SHALL have port dd, output, DW bits: scanned data word.
REQ-013 SHALL have port dd_addr, output, AW bits: array address of the word on dd.
REQ-014 SHALL have port dd_valid, output, 1 bit: dd and dd_addr hold a valid word.
REQ-015 SHALL have port dd_ready, input, 1 bit: consumer accepts the word.
REQ-016 SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a scan.

Function
REQ-018 SHALL hold a DEPTH x DW storage array; when wr_en=1, wr_data is written to wr_addr on the clock edge, in any state.
REQ-019 SHALL implement the states IDLE, SCAN and FIN.
REQ-020 In IDLE with start=1, SHALL on the next edge capture base_addr and count, load dd=array[base_addr] and dd_addr=base_addr, set dd_valid=1 and busy=1, and enter SCAN.
REQ-021 SHALL ignore start while busy=1 or in FIN.
REQ-022 A transfer SHALL occur on an edge where dd_valid=1 and dd_ready=1.
REQ-023 While dd_valid=1 and dd_ready=0, dd and dd_addr SHALL remain stable.
REQ-024 On a non-final transfer, SHALL load the next word at the same edge, giving zero-bubble throughput of one word per cycle.
REQ-025 The next address SHALL be dd_addr+1 modulo DEPTH, so address 15 wraps to 0.
REQ-026 On the final transfer, SHALL clear dd_valid and enter FIN; in FIN, done=1 and busy=1 for exactly one cycle, then return to IDLE with busy=0.
REQ-027 A loaded word SHALL be the array content before any write on that same edge; a write to an address already loaded into dd SHALL NOT alter dd.
REQ-028 The remaining-word counter SHALL be AW+1 bits wide, so that count=0 yields exactly DEPTH transfers.
REQ-029 dd, dd_addr, dd_valid, busy and done SHALL be registered outputs.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, dd=0, dd_addr=0, dd_valid=0, busy=0 and done=0, including mid-scan.
REQ-031 Reset SHALL NOT clear the array contents; the array is not reset.
REQ-032 After rst deasserts, a start SHALL be required before any dd_valid.

Verification
REQ-033 Fill entry i with i*17, then start with base 0, count 0, and dd_ready held at 1 -> 16 back-to-back words 0x00,0x11,...,0xFF at addresses 0..15, then done for 1 cycle.
REQ-034 Start with base 14, count 4 -> addresses 14,15,0,1 in order, then done.
REQ-035 Hold dd_ready=0 for 5 cycles on word 2 -> dd and dd_addr stable for those cycles, with no loss or duplication.
REQ-036 Write 0xA5 to address 3 on the same edge that address 3 is loaded -> dd shows the old value; a later scan returns 0xA5.
REQ-037 Pulse start during a scan -> ignored, and the word count is unchanged.
REQ-038 Assert rst after the 3rd transfer -> all outputs 0 at once, no done pulse, and the array retains its data.
